// File: rtl/rx_cp_strip_pair_if.sv
// rx_cp_strip_pair_if: sample-in / pair-out bus of the CP strip and pairing stage.
interface rx_cp_strip_pair_if #(parameter int W = 32);
    logic         i_valid;
    logic         i_sof;
    logic [W-1:0] i_data;
    logic [W-1:0] o1_data;
    logic [W-1:0] o2_data;
    logic         o_valid;
    logic         o_sos;
    logic         o_eos;
    logic         o_err;
    modport master (output i_valid, i_sof, i_data, input o1_data, o2_data, o_valid, o_sos, o_eos, o_err);
    modport slave  (input i_valid, i_sof, i_data, output o1_data, o2_data, o_valid, o_sos, o_eos, o_err);
endinterface

// File: rtl/rx_cp_strip_pair.sv
// rx_cp_strip_pair: drops the cyclic prefix and emits body samples as (even, odd) pairs.
// Optional RX_HALF_SCALE_EN halves each component with round-half-up and saturation.
module rx_cp_strip_pair #(
    parameter int DATA_WIDTH        = 16,
    parameter int DOUBLE_DATA_WIDTH = 32,
    parameter int N_FFT             = 16,
    parameter int CP_LEN            = 4
) (
    input logic              clk,
    input logic              i_rst_n,
    rx_cp_strip_pair_if.slave bus
);
    localparam int CW = CP_LEN > 0 ? $clog2(CP_LEN + 1) : 1;
    localparam int BW = $clog2(N_FFT + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CP   = 2'd1;
    localparam logic [1:0] BODY = 2'd2;

`ifdef RX_HALF_SCALE_EN
    function automatic logic [DATA_WIDTH-1:0] half(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0] t;
        t = {x[DATA_WIDTH-1], x} + {{DATA_WIDTH{1'b0}}, 1'b1};
        return (x == {1'b0, {(DATA_WIDTH-1){1'b1}}}) ? {2'b00, {(DATA_WIDTH-2){1'b1}}} : t[DATA_WIDTH:1];
    endfunction
    function automatic logic [DOUBLE_DATA_WIDTH-1:0] scale(input logic [DOUBLE_DATA_WIDTH-1:0] s);
        return {half(s[2*DATA_WIDTH-1:DATA_WIDTH]), half(s[DATA_WIDTH-1:0])};
    endfunction
`else
    function automatic logic [DOUBLE_DATA_WIDTH-1:0] scale(input logic [DOUBLE_DATA_WIDTH-1:0] s);
        return {s[2*DATA_WIDTH-1:DATA_WIDTH], s[DATA_WIDTH-1:0]};
    endfunction
`endif

    logic [1:0]                   state_q, state_d;
    logic [CW-1:0]                cp_q, cp_d;
    logic [BW-1:0]                body_q, body_d;
    logic [DOUBLE_DATA_WIDTH-1:0] held_q, held_d, o1_q, o1_d, o2_q, o2_d;
    logic                         valid_q, valid_d, sos_q, sos_d, eos_q, eos_d, err_q, err_d;
    logic                         last;

    assign last = (state_q == BODY) && (body_q == BW'(N_FFT - 1));

    always_comb begin
        state_d = state_q;
        cp_d    = cp_q;
        body_d  = body_q;
        held_d  = held_q;
        o1_d    = o1_q;
        o2_d    = o2_q;
        valid_d = 1'b0;
        sos_d   = 1'b0;
        eos_d   = 1'b0;
        err_d   = 1'b0;
        if (bus.i_valid) begin
            // a sof landing on the final body sample still completes that symbol's last pair
            if (state_q == BODY && body_q[0] && (!bus.i_sof || last)) begin
                o1_d    = scale(held_q);
                o2_d    = scale(bus.i_data);
                valid_d = 1'b1;
                sos_d   = body_q == BW'(1);
                eos_d   = last && !bus.i_sof;
            end
            if (bus.i_sof) begin
                err_d = state_q != IDLE;
                if (CP_LEN == 0) begin
                    state_d = BODY;
                    body_d  = BW'(1);
                    held_d  = bus.i_data;
                end else if (CP_LEN == 1) begin
                    state_d = BODY;
                    body_d  = '0;
                end else begin
                    state_d = CP;
                    cp_d    = CW'(1);
                end
            end else if (state_q == CP) begin
                cp_d = cp_q + CW'(1);
                if (cp_q == CW'(CP_LEN - 1)) begin
                    state_d = BODY;
                    body_d  = '0;
                end
            end else if (state_q == BODY) begin
                if (!body_q[0]) held_d = bus.i_data;
                body_d = body_q + BW'(1);
                if (last) state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cp_q    <= '0;
            body_q  <= '0;
            held_q  <= '0;
            o1_q    <= '0;
            o2_q    <= '0;
            valid_q <= 1'b0;
            sos_q   <= 1'b0;
            eos_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cp_q    <= cp_d;
            body_q  <= body_d;
            held_q  <= held_d;
            o1_q    <= o1_d;
            o2_q    <= o2_d;
            valid_q <= valid_d;
            sos_q   <= sos_d;
            eos_q   <= eos_d;
            err_q   <= err_d;
        end
    end

    assign bus.o1_data = o1_q;
    assign bus.o2_data = o2_q;
    assign bus.o_valid = valid_q;
    assign bus.o_sos   = sos_q;
    assign bus.o_eos   = eos_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_rx_cp_strip_pair.sv
// tb_rx_cp_strip_pair: table vectors, directed corner sequences and random traffic on CP_LEN=4 and CP_LEN=0 instances.
module tb_rx_cp_strip_pair;
    localparam int N = 16;
    logic clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_cp_strip_pair_if b0 ();
    rx_cp_strip_pair_if b1 ();
    rx_cp_strip_pair #(.CP_LEN(4)) u0 (.clk(clk), .i_rst_n(i_rst_n), .bus(b0));
    rx_cp_strip_pair #(.CP_LEN(0)) u1 (.clk(clk), .i_rst_n(i_rst_n), .bus(b1));

    int vec = 0;
    int bad = 0;
    int cpl [2] = '{4, 0};
    int pos [2];
    logic [31:0] held [2], eo1 [2], eo2 [2];
    logic ev [2], es [2], ee [2], er [2];
    int pc;
    logic [31:0] sos_o1;

    typedef struct {
        logic        v, s;
        logic [31:0] d;
        logic        ov, sos, eos;
        logic [31:0] o1, o2;
    } vec_t;
    vec_t tbl [21];

    function automatic logic [31:0] scl(input logic [31:0] x);
`ifdef RX_HALF_SCALE_EN
        int re, im;
        re = $signed(x[31:16]);
        im = $signed(x[15:0]);
        re = (re + 1) >>> 1;
        im = (im + 1) >>> 1;
        if (re > 16383) re = 16383;
        if (im > 16383) im = 16383;
        return {re[15:0], im[15:0]};
`else
        return x;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pos[k] = -1; held[k] = '0; eo1[k] = '0; eo2[k] = '0;
            ev[k] = 1'b0; es[k] = 1'b0; ee[k] = 1'b0; er[k] = 1'b0;
        end
    endtask

    // pos = samples since the symbol's sof; body index = pos - CP length
    task automatic model_step(input int k, input logic v, input logic s, input logic [31:0] d);
        int b;
        ev[k] = 1'b0; es[k] = 1'b0; ee[k] = 1'b0; er[k] = 1'b0;
        if (!v) return;
        if (s) begin
            if (pos[k] >= 0) begin
                er[k] = 1'b1;
                if (pos[k] + 1 == cpl[k] + N - 1) begin
                    ev[k] = 1'b1; eo1[k] = scl(held[k]); eo2[k] = scl(d);
                end
            end
            pos[k] = 0;
        end else if (pos[k] >= 0) pos[k]++;
        else return;
        b = pos[k] - cpl[k];
        if (b >= 0) begin
            if (b % 2 == 0) held[k] = d;
            else begin
                ev[k] = 1'b1; eo1[k] = scl(held[k]); eo2[k] = scl(d);
                es[k] = (b == 1); ee[k] = (b == N - 1);
            end
            if (b == N - 1) pos[k] = -1;
        end
    endtask

    task automatic check_both();
        chk("u0 o_valid", 32'(b0.o_valid), 32'(ev[0]));
        chk("u0 o_sos", 32'(b0.o_sos), 32'(es[0]));
        chk("u0 o_eos", 32'(b0.o_eos), 32'(ee[0]));
        chk("u0 o_err", 32'(b0.o_err), 32'(er[0]));
        chk("u0 o1_data", b0.o1_data, eo1[0]);
        chk("u0 o2_data", b0.o2_data, eo2[0]);
        chk("u1 o_valid", 32'(b1.o_valid), 32'(ev[1]));
        chk("u1 o_sos", 32'(b1.o_sos), 32'(es[1]));
        chk("u1 o_eos", 32'(b1.o_eos), 32'(ee[1]));
        chk("u1 o_err", 32'(b1.o_err), 32'(er[1]));
        chk("u1 o1_data", b1.o1_data, eo1[1]);
        chk("u1 o2_data", b1.o2_data, eo2[1]);
    endtask

    task automatic step(input logic v, input logic s, input logic [31:0] d);
        b0.i_valid = v; b0.i_sof = s; b0.i_data = d;
        b1.i_valid = v; b1.i_sof = s; b1.i_data = d;
        model_step(0, v, s, d);
        model_step(1, v, s, d);
        @(posedge clk);
        #1;
        check_both();
        if (b0.o_valid) pc++;
        if (b0.o_valid && b0.o_sos) sos_o1 = b0.o1_data;
    endtask

    initial begin
        for (int i = 0; i < 20; i++) begin
            int od;
            od = (i % 2 == 1) ? i : i - 1;
            tbl[i] = '{1'b1, i == 0, 32'(i), i >= 5 && i % 2 == 1, i == 5, i == 19,
                       i < 5 ? 32'h0 : scl(32'(od - 1)), i < 5 ? 32'h0 : scl(32'(od))};
        end
        tbl[20] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, scl(32'd18), scl(32'd19)};

        model_reset();
        b0.i_valid = 0; b0.i_sof = 0; b0.i_data = '0;
        b1.i_valid = 0; b1.i_sof = 0; b1.i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_both();
        i_rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            chk($sformatf("tbl%0d o_valid", i), 32'(b0.o_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d o_sos", i), 32'(b0.o_sos), 32'(tbl[i].sos));
            chk($sformatf("tbl%0d o_eos", i), 32'(b0.o_eos), 32'(tbl[i].eos));
            chk($sformatf("tbl%0d o1", i), b0.o1_data, tbl[i].o1);
            chk($sformatf("tbl%0d o2", i), b0.o2_data, tbl[i].o2);
        end

        pc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i == 0, 32'(i));
            step(1'b0, 1'b1, $urandom);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("gap pair count", 32'(pc), 32'd8);

        pc = 0;
        for (int i = 0; i < 11; i++) step(1'b1, i == 0, 32'(i));
        step(1'b1, 1'b1, 32'd11);
        chk("abort err", 32'(b0.o_err), 32'd1);
        chk("abort pair count", 32'(pc), 32'd3);
        for (int i = 12; i < 31; i++) step(1'b1, 1'b0, 32'(i));

        pc = 0;
        for (int i = 0; i < 40; i++) step(1'b1, i % 20 == 0, 32'(i));
        chk("b2b pair count", 32'(pc), 32'd16);
        chk("b2b second sos o1", sos_o1, scl(32'd24));

        for (int i = 0; i < 19; i++) step(1'b1, i == 0, 32'(i));
        step(1'b1, 1'b1, 32'd19);
        chk("sof-on-last valid", 32'(b0.o_valid), 32'd1);
        chk("sof-on-last eos", 32'(b0.o_eos), 32'd0);
        chk("sof-on-last err", 32'(b0.o_err), 32'd1);
        for (int i = 20; i < 39; i++) step(1'b1, 1'b0, 32'(i));

        step(1'b1, 1'b1, 32'h0001_FFFF);
        step(1'b1, 1'b0, 32'h1234_5678);
        chk("cp0 first o1", b1.o1_data, scl(32'h0001_FFFF));
        chk("cp0 first sos", 32'(b1.o_sos), 32'd1);
        step(1'b1, 1'b1, 32'h7FFF_8000);
        step(1'b1, 1'b0, 32'h0003_FFFD);
`ifdef RX_HALF_SCALE_EN
        chk("scale o1", b1.o1_data, 32'h3FFF_C000);
        chk("scale o2", b1.o2_data, 32'h0002_FFFF);
`else
        chk("scale o1", b1.o1_data, 32'h7FFF_8000);
        chk("scale o2", b1.o2_data, 32'h0003_FFFD);
`endif

        for (int i = 0; i < 6; i++) step(1'b1, i == 0, 32'(i + 100));
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_both();
        @(posedge clk);
        #1;
        check_both();
        i_rst_n = 1'b1;
        pc = 0;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'(i + 200));
        chk("post-reset pairs", 32'(pc), 32'd0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(3, 0) != 0, $urandom_range(29, 0) == 0, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
